nway_assoc_cache: RTL
=====================

NWAY_ASSOC_CACHE -- requirements
Module: nway_assoc_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of data words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter WAYS, default 4, associativity, power of two, 2..8.
REQ-004 SHALL have parameter SETS, default 8, set count, power of two, >=2.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset, asynchronous, active-high.
REQ-007 SHALL have port req_i, input, 1 bit, request valid.
REQ-008 SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have ports addr_i (ADDR_WIDTH) and wdata_i (DATA_WIDTH), inputs: request address and write data.
REQ-010 SHALL have port ready_o, output, 1 bit, high when a request can be accepted.
REQ-011 SHALL have ports resp_valid_o (1), rdata_o (DATA_WIDTH) and hit_o (1), outputs: response strobe, data, hit flag.
REQ-012 SHALL have ports mem_req_o (1), mem_we_o (1), mem_addr_o (ADDR_WIDTH), mem_wdata_o (DATA_WIDTH), outputs: backing-memory request.
REQ-013 SHALL have ports mem_ack_i (1) and mem_rdata_i (DATA_WIDTH), inputs: memory completion and read data.

Function
REQ-014 SHALL use one-word lines: index = addr_i[2 +: log2(SETS)], tag = remaining upper bits, addr_i[1:0] ignored.
REQ-015 SHALL store per line a valid bit, tag and data word, plus a per-way age counter of log2(WAYS) bits per set.
REQ-016 SHALL implement states IDLE, LOOKUP, MEM, RESP; ready_o = 1 only in IDLE.
REQ-017 SHALL accept a request on an edge where req_i && ready_o, latch we_i/addr_i/wdata_i, go to LOOKUP.
REQ-018 SHALL, on LOOKUP exit, flag a hit when exactly one valid way in the set matches the tag; read hit -> RESP, any other case -> MEM.
REQ-019 SHALL, on write hit, update the hit way's data at LOOKUP exit (write-through); write miss SHALL NOT allocate.
REQ-020 SHALL, in MEM, hold mem_req_o = 1 with mem_we_o = latched we, mem_addr_o = latched address with [1:0] = 0, mem_wdata_o = latched data, all stable until mem_ack_i sampled high; then -> RESP.
REQ-021 SHALL, on read-miss completion, fill the victim way with valid = 1, tag, mem_rdata_i; victim = lowest-numbered invalid way, else way with maximum age.
REQ-022 SHALL, on every hit or fill of way w, set age[w] = 0 and increment ages of ways with age < old age[w]; write misses leave ages unchanged.
REQ-023 SHALL assert resp_valid_o for exactly one cycle in RESP with rdata_o = read data (cache or memory) or latched write data, hit_o = lookup result; then -> IDLE.
REQ-024 SHALL give read-hit latency: resp_valid_o high in the second cycle after the accepting edge.
REQ-025 SHALL ignore mem_ack_i outside MEM and req_i outside IDLE.
REQ-026 SHALL hold rdata_o and hit_o stable between responses; mem_req_o = 0 outside MEM.

Reset
REQ-027 SHALL, while rst is high, asynchronously force state IDLE, all valid bits 0, age of way w = w in every set, resp_valid_o = 0, hit_o = 0, rdata_o = 0, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0; ready_o = 1.
REQ-028 SHALL abandon any in-flight request on reset, including in MEM, with no cache update and no response.

Verification (WAYS=4, SETS=8, set 0 = addresses 0x000, 0x020, 0x040, ...)
REQ-029 SHALL cover: read 0x100 after reset -> mem_req_o with mem_addr_o=0x100; ack with 0xDEADBEEF -> resp hit_o=0, rdata_o=0xDEADBEEF; re-read -> hit_o=1, same data, resp two cycles after accept.
REQ-030 SHALL cover: read 0x000, 0x020, 0x040, 0x060, then 0x080 -> 0x080 evicts 0x000; read 0x020 hits; read 0x000 misses.
REQ-031 SHALL cover: fill 0x000..0x060, re-read 0x000, read 0x080 -> 0x020 evicted, 0x000 still hits.
REQ-032 SHALL cover: write 0x12345678 to cached 0x020 -> hit_o=1, memory write with mem_we_o=1; later read 0x020 hits returning 0x12345678; write to uncached 0x0A0 -> hit_o=0, later read 0x0A0 misses.
REQ-033 SHALL cover: mem_ack_i delayed 5 cycles -> mem_* outputs stable and ready_o=0 throughout; stray mem_ack_i in IDLE has no effect.
REQ-034 SHALL cover: rst asserted mid-MEM -> mem_req_o drops immediately, no resp_valid_o, ready_o=1 after release, previously cached 0x020 misses.

Source files
------------

// File: rtl/nway_assoc_cache.sv
// N-way set-associative write-through cache with one-word lines.
// Age-based replacement; misses and all writes go to backing memory.
module nway_assoc_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  hit_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = ADDR_WIDTH - 2;
    localparam int TAG_W  = LINE_W - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, MEM, RESP} state_e;

    state_e                  state_q;
    logic                    we_q;
    logic [LINE_W-1:0]       line_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    lhit_q;

    logic [WAYS-1:0]             valid_q [SETS];
    logic [WAYS-1:0][WAY_W-1:0]  age_q   [SETS];
    logic [TAG_W-1:0]            tag_mem_q  [SETS][WAYS];
    logic [DATA_WIDTH-1:0]       data_mem_q [SETS][WAYS];

    logic [IDX_W-1:0]            idx;
    logic [TAG_W-1:0]            tag;
    logic [WAYS-1:0]             match;
    logic                        hit;
    logic [WAY_W-1:0]            hit_way;
    logic [WAY_W-1:0]            victim;
    logic [WAY_W-1:0]            vmax;
    logic                        vfound;
    logic [WAY_W-1:0]            touch_way;
    logic [WAY_W-1:0]            touch_age;
    logic [WAYS-1:0][WAY_W-1:0]  age_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    assign idx     = line_q[IDX_W-1:0];
    assign tag     = line_q[LINE_W-1:IDX_W];
    assign ready_o = (state_q == IDLE);

    always_comb begin
        match   = '0;
        hit_way = '0;
        victim  = '0;
        vmax    = '0;
        vfound  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid_q[idx][w] && (tag_mem_q[idx][w] == tag);
            if (match[w]) hit_way = WAY_W'(w);
        end
        hit = $onehot(match);
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_q[idx][w] && !vfound) begin
                victim = WAY_W'(w);
                vfound = 1'b1;
            end
        end
        for (int w = 1; w < WAYS; w++) begin
            if (age_q[idx][w] > age_q[idx][vmax]) vmax = WAY_W'(w);
        end
        if (!vfound) victim = vmax;
    end

    // The touched way becomes youngest; only ways younger than it age.
    assign touch_way = (state_q == LOOKUP) ? hit_way : victim;
    assign touch_age = age_q[idx][touch_way];

    always_comb begin
        age_d = age_q[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way)
                age_d[w] = '0;
            else if (age_q[idx][w] < touch_age)
                age_d[w] = age_q[idx][w] + WAY_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            line_q       <= '0;
            wdata_q      <= '0;
            lhit_q       <= 1'b0;
            resp_valid_o <= 1'b0;
            hit_o        <= 1'b0;
            rdata_o      <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        line_q  <= addr_i[ADDR_WIDTH-1:2];
                        wdata_q <= wdata_i;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    lhit_q <= hit;
                    if (hit) age_q[idx] <= age_d;
                    if (hit && !we_q) begin
                        state_q      <= RESP;
                        resp_valid_o <= 1'b1;
                        hit_o        <= 1'b1;
                        rdata_o      <= data_mem_q[idx][hit_way];
                    end else begin
                        state_q     <= MEM;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= we_q;
                        mem_addr_o  <= {line_q, 2'b00};
                        mem_wdata_o <= wdata_q;
                    end
                end
                MEM: begin
                    if (mem_ack_i) begin
                        state_q      <= RESP;
                        mem_req_o    <= 1'b0;
                        resp_valid_o <= 1'b1;
                        hit_o        <= lhit_q;
                        rdata_o      <= we_q ? wdata_q : mem_rdata_i;
                        if (!we_q) begin
                            valid_q[idx][victim] <= 1'b1;
                            age_q[idx]           <= age_d;
                        end
                    end
                end
                RESP: begin
                    resp_valid_o <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    // Tag/data storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state_q == LOOKUP && hit && we_q)
            data_mem_q[idx][hit_way] <= wdata_q;
        if (state_q == MEM && mem_ack_i && !we_q) begin
            tag_mem_q[idx][victim]  <= tag;
            data_mem_q[idx][victim] <= mem_rdata_i;
        end
    end

endmodule
